// File: rtl/frame_buffer_pp.sv
// Ping-pong frame buffer: camera FIFO -> two BRAM banks -> display FIFO.
// Optional colour-bar source for the reader when TEST_PATTERN_EN is defined.
module frame_buffer_pp #(
    parameter int DATA_WIDTH = 12,
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_rd,
    input  logic [DATA_WIDTH:0]   i_data,
    input  logic                  i_empty,
    output logic                  o_wr,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_full,
`ifdef TEST_PATTERN_EN
    input  logic                  i_pat_sel,
`endif
    output logic                  o_frame_ok,
    output logic [7:0]            o_drop_cnt
);
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
    localparam int ADDR_W    = $clog2(FRAME_PIX);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIX - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_WAIT} wstate_t;
    wstate_t state, state_n;

    logic                  in_vld;
    logic                  sof;
    logic [DATA_WIDTH-1:0] pix;
    logic [ADDR_W-1:0]     wr_addr, wr_addr_n;
    logic                  we, complete, drop;
    logic                  wr_bank, pend, swap;

    logic [DATA_WIDTH-1:0] mem0 [FRAME_PIX];
    logic [DATA_WIDTH-1:0] mem1 [FRAME_PIX];

    logic [ADDR_W-1:0]     rd_addr;
    logic                  issue, rd_eof, src_ok, inflight;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] skid [2];
    logic                  rp, wp;
    logic [1:0]            cnt, occ;

    assign o_rd = ~i_empty & ~i_rst;
    assign sof  = in_vld & i_data[DATA_WIDTH];
    assign pix  = i_data[DATA_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            in_vld  <= 1'b0;
            state   <= W_IDLE;
            wr_addr <= '0;
        end else begin
            in_vld  <= o_rd;
            state   <= state_n;
            wr_addr <= wr_addr_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            W_IDLE:  if (sof) state_n = W_FILL;
            W_FILL:  if (complete) state_n = swap ? W_IDLE : W_WAIT;
            W_WAIT:  if (swap) state_n = W_IDLE;
            default: state_n = W_IDLE;
        endcase
    end

    always_comb begin
        we        = 1'b0;
        drop      = 1'b0;
        complete  = 1'b0;
        wr_addr_n = wr_addr;
        unique case (state)
            W_IDLE: begin
                if (sof) begin
                    we        = 1'b1;
                    wr_addr_n = '0;
                end
            end
            W_FILL: begin
                if (in_vld) begin
                    we = 1'b1;
                    if (sof) begin
                        drop      = 1'b1;
                        wr_addr_n = '0;
                    end else begin
                        wr_addr_n = wr_addr + ADDR_W'(1);
                        complete  = (wr_addr + ADDR_W'(1)) == LAST;
                    end
                end
            end
            default: ;
        endcase
    end

    // First frame swaps at once; later ones wait for the reader's frame end.
    assign swap = (complete & ~o_frame_ok) | (rd_eof & (pend | complete));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_bank    <= 1'b0;
            pend       <= 1'b0;
            o_frame_ok <= 1'b0;
            o_drop_cnt <= 8'd0;
        end else begin
            if (swap) wr_bank <= ~wr_bank;
            if (swap) pend <= 1'b0;
            else if (complete) pend <= 1'b1;
            if (complete) o_frame_ok <= 1'b1;
            if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we && !wr_bank) mem0[wr_addr_n] <= pix;
        if (we && wr_bank)  mem1[wr_addr_n] <= pix;
    end

    // Slot accounting includes the read in flight and this cycle's pop.
    assign occ    = cnt + {1'b0, inflight};
    assign o_wr   = (cnt != 2'd0) & ~i_full;
    assign o_data = skid[rp];
    assign issue  = src_ok & ~i_full & ((occ < 2'd2) | o_wr);
    assign rd_eof = issue & (rd_addr == LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_addr  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) rd_addr <= rd_eof ? '0 : rd_addr + ADDR_W'(1);
        end
    end

`ifdef TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BPW   = $clog2(BAR_W + 1);
    localparam int CW    = DATA_WIDTH / 3;
    localparam logic [BPW-1:0] BP_LAST = BPW'(BAR_W - 1);

    logic                  pat_mode;
    logic [2:0]            bar;
    logic [BPW-1:0]        bpos;
    logic [DATA_WIDTH-1:0] bar_pix;

    assign src_ok  = o_frame_ok | pat_mode;
    assign bar_pix = DATA_WIDTH'({{CW{~bar[1]}}, {CW{~bar[2]}}, {CW{~bar[0]}}});

    // Mode only changes while the reader sits on a frame boundary.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pat_mode <= 1'b0;
            bar      <= 3'd0;
            bpos     <= '0;
        end else begin
            if (rd_eof || (rd_addr == '0 && !issue)) pat_mode <= i_pat_sel;
            if (issue) begin
                if (bpos == BP_LAST) begin
                    bpos <= '0;
                    bar  <= bar + 3'd1;
                end else begin
                    bpos <= bpos + BPW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (issue) rdata <= pat_mode ? bar_pix :
                            (wr_bank ? mem0[rd_addr] : mem1[rd_addr]);
    end
`else
    assign src_ok = o_frame_ok;

    always_ff @(posedge i_clk) begin
        if (issue) rdata <= wr_bank ? mem0[rd_addr] : mem1[rd_addr];
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            skid[0] <= '0;
            skid[1] <= '0;
            rp      <= 1'b0;
            wp      <= 1'b0;
            cnt     <= 2'd0;
        end else begin
            if (inflight) begin
                skid[wp] <= rdata;
                wp       <= ~wp;
            end
            if (o_wr) rp <= ~rp;
            cnt <= cnt + {1'b0, inflight} - {1'b0, o_wr};
        end
    end
endmodule

// File: tb/tb_frame_buffer_pp.sv
// Directed bench for frame_buffer_pp with an 8x4 frame (32 pixels).
module tb_frame_buffer_pp;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd;
    logic [DW:0]   din;
    logic          empty;
    logic          wr;
    logic [DW-1:0] dout;
    logic          full;
    logic          frame_ok;
    logic [7:0]    drop;
`ifdef TEST_PATTERN_EN
    logic          pat_sel = 1'b0;
    logic [DW-1:0] bars [8];
`endif

    always #4 clk = ~clk;

    frame_buffer_pp #(.DATA_WIDTH(DW), .H_ACTIVE(8), .V_ACTIVE(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .o_rd       (rd),
        .i_data     (din),
        .i_empty    (empty),
        .o_wr       (wr),
        .o_data     (dout),
        .i_full     (full),
`ifdef TEST_PATTERN_EN
        .i_pat_sel  (pat_sel),
`endif
        .o_frame_ok (frame_ok),
        .o_drop_cnt (drop)
    );

    logic [DW:0]   inq [$];
    logic [DW-1:0] outq [$];
    logic [DW-1:0] last_out = '0;
    int            full_wr = 0;
    int            pass_n = 0;
    int            fail_n = 0;
    int            total = 0;

    // Input FIFO model: data appears the cycle after a read of a non-empty FIFO.
    always @(posedge clk) begin
        if (rd && !empty) begin
            #1;
            din   = inq.pop_front();
            empty = (inq.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (wr) begin
            outq.push_back(dout);
            last_out = dout;
            if (full) full_wr++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int base, input int n);
        for (int k = 0; k < n; k++)
            inq.push_back({(k == 0), DW'(base + k)});
        empty = 1'b0;
    endtask

    task automatic wait_base(input string tag, input int base, input int budget);
        int c = 0;
        while ((int'(last_out) & 'hF00) != base && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, int'(last_out) & 'hF00, base);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int c = 0;
        while (!empty && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, int'(empty), 1);
    endtask

    task automatic wait_ok(input string tag, input int budget);
        int c = 0;
        while (!frame_ok && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, int'(frame_ok), 1);
    endtask

    // Output must be whole raster frames; order code lists (base>>8)+1 per run.
    task automatic seg_check(input string tag, input int s, input int e, input int exp_code);
        int errs = 0;
        int code = 0;
        int bb = -1;
        int prev = -1;
        for (int i = s; i < e; i++) begin
            int k = (i - s) % 32;
            if (k == 0) begin
                bb = int'(outq[i]);
                if ((bb & 'hFF) != 0) errs++;
                if (bb != prev) code = (code << 4) | ((bb >> 8) + 1);
                prev = bb;
            end
            if (int'(outq[i]) != bb + k) errs++;
        end
        check({tag, "_errs"}, errs, 0);
        check({tag, "_order"}, code, exp_code);
    endtask

    initial begin
        int bad;
        int n0;
        int idx_r;
        rst   = 1'b1;
        empty = 1'b1;
        full  = 1'b0;
        din   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr", int'(wr), 0);
        check("rst_data", int'(dout), 0);
        check("rst_frame_ok", int'(frame_ok), 0);
        check("rst_drop", int'(drop), 0);
        check("rst_rd", int'(rd), 0);
        rst = 1'b0;

        push_frame('h000, 32);
        wait_drain("t1_drain", 100);
        check("t1_ok_before_last", int'(frame_ok), 0);
        @(negedge clk);
        check("t1_ok_after_last", int'(frame_ok), 1);
        repeat (100) @(negedge clk);
        bad = -1;
        for (int k = 0; k < 64; k++) begin
            if (k >= outq.size() || int'(outq[k]) != k % 32) begin
                bad = k;
                break;
            end
        end
        check("t1_stream_bad_idx", bad, -1);

        push_frame('h100, 32);
        wait_base("t2_a_seen", 'h100, 200);
        push_frame('h200, 32);
        wait_base("t2_b_seen", 'h200, 200);
        repeat (40) @(negedge clk);

        push_frame('h300, 20);
        push_frame('h400, 32);
        wait_base("t3_d_seen", 'h400, 300);
        check("t3_drop", int'(drop), 1);
        repeat (40) @(negedge clk);

        n0 = outq.size();
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            full = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        full = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_wr_while_full", full_wr, 0);
        check("t4_progress", int'(outq.size() - n0 > 100), 1);
        seg_check("t4_seq", 0, outq.size(), 'h1235);

        push_frame('h500, 10);
        wait_drain("t5_drain", 100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_wr", int'(wr), 0);
        check("t5_data", int'(dout), 0);
        check("t5_frame_ok", int'(frame_ok), 0);
        check("t5_drop", int'(drop), 0);
        idx_r = outq.size();
        repeat (50) @(negedge clk);
        check("t5_no_wr_idle", outq.size() - idx_r, 0);
        push_frame('h600, 32);
        wait_ok("t5_new_ok", 100);
        repeat (100) @(negedge clk);
        seg_check("t5_seq", idx_r, outq.size(), 'h7);

`ifdef TEST_PATTERN_EN
        bars[0] = 12'hFFF; bars[1] = 12'hFF0; bars[2] = 12'h0FF; bars[3] = 12'h0F0;
        bars[4] = 12'hF0F; bars[5] = 12'hF00; bars[6] = 12'h00F; bars[7] = 12'h000;
        pat_sel = 1'b1;
        repeat (80) @(negedge clk);
        bad = -1;
        for (int i = idx_r; i < outq.size(); i++) begin
            if (outq[i] == 12'hFFF) begin
                bad = i;
                break;
            end
        end
        check("t6_found", int'(bad >= 0), 1);
        if (bad >= 0) begin
            for (int k = 0; k < 32; k++)
                check("t6_bar",
                      (bad + k < outq.size()) ? int'(outq[bad + k]) : -1,
                      int'(bars[k % 8]));
        end
`endif

        $display("%0d/%0d checks passed", pass_n, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end
endmodule
